// File: rtl/cdb_arbiter_if.sv
// Requester/broadcast bundle between the execution units, the CDB arbiter and the data_bus channels.
// The master side drives requests and control; the slave side (the arbiter) returns grants and broadcasts.
interface cdb_arbiter_if #(
  parameter int REQUESTERS = 5,
  parameter int CHANNELS   = 2,
  parameter int PAYLOAD_W  = 72
) ();
  localparam int SRC_W = $clog2(REQUESTERS);

  logic                                  flush;
  logic [CHANNELS-1:0]                   chan_enable;
  logic [REQUESTERS-1:0]                 req;
  logic [REQUESTERS-1:0][PAYLOAD_W-1:0]  req_payload;
  logic [REQUESTERS-1:0]                 grant;
  logic [CHANNELS-1:0]                   cdb_valid;
  logic [CHANNELS-1:0][PAYLOAD_W-1:0]    cdb_payload;
  logic [CHANNELS-1:0][SRC_W-1:0]        cdb_source;
  logic [REQUESTERS-1:0]                 starved;

  modport master (
    output flush, chan_enable, req, req_payload,
    input  grant, cdb_valid, cdb_payload, cdb_source, starved
  );

  modport slave (
    input  flush, chan_enable, req, req_payload,
    output grant, cdb_valid, cdb_payload, cdb_source, starved
  );
endinterface

// File: rtl/cdb_arbiter.sv
// N-requester to M-channel CDB arbiter: rotating priority with starvation escalation, grant is combinational,
// broadcast is registered one cycle later; requesters hold req until granted, flush or a zero mask grants nothing.
module cdb_arbiter #(
  parameter int REQUESTERS = 5,
  parameter int CHANNELS   = 2,
  parameter int PAYLOAD_W  = 72,
  parameter int MAX_WAIT   = 7
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
);
  localparam int SRC_W = $clog2(REQUESTERS);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(REQUESTERS - 1);

  logic [SRC_W-1:0]                     rr_ptr_q, rr_ptr_d;
  logic [REQUESTERS-1:0][CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CHANNELS-1:0]                  cdb_valid_q, cdb_valid_d;
  logic [CHANNELS-1:0][PAYLOAD_W-1:0]   cdb_payload_q, cdb_payload_d;
  logic [CHANNELS-1:0][SRC_W-1:0]       cdb_source_q, cdb_source_d;

  logic [REQUESTERS-1:0] grant;
  logic [REQUESTERS-1:0] starved;
  logic [SRC_W-1:0]      last_win;
  logic [SRC_W-1:0]      idx;
  int                    win_rank [REQUESTERS];
  int                    chan_rank [CHANNELS];
  int                    n_avail;
  int                    n_win;
  int                    sum;

  always_comb begin
    for (int i = 0; i < REQUESTERS; i++) begin
      starved[i] = (wait_cnt_q[i] == CNT_MAX);
    end
  end

  // Two sweeps from rr_ptr: starved requesters first, then everyone else; a winner's rank picks its channel.
  always_comb begin
    grant    = '0;
    n_avail  = 0;
    n_win    = 0;
    last_win = rr_ptr_q;
    idx      = '0;
    sum      = 0;
    for (int i = 0; i < REQUESTERS; i++) begin
      win_rank[i] = 0;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      chan_rank[c] = n_avail;
      if (bus.chan_enable[c]) begin
        n_avail = n_avail + 1;
      end
    end
    if (!reset || bus.flush) begin
      n_avail = 0;
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int off = 0; off < REQUESTERS; off++) begin
        sum = int'(rr_ptr_q) + off;
        if (sum >= REQUESTERS) begin
          sum = sum - REQUESTERS;
        end
        idx = SRC_W'(sum);
        if (bus.req[idx] && (starved[idx] == (pass == 0)) && (n_win < n_avail)) begin
          grant[idx]    = 1'b1;
          win_rank[idx] = n_win;
          n_win         = n_win + 1;
          last_win      = idx;
        end
      end
    end
  end

  always_comb begin
    cdb_valid_d   = '0;
    cdb_payload_d = cdb_payload_q;
    cdb_source_d  = cdb_source_q;
    rr_ptr_d      = rr_ptr_q;
    wait_cnt_d    = wait_cnt_q;

    for (int c = 0; c < CHANNELS; c++) begin
      for (int i = 0; i < REQUESTERS; i++) begin
        if (bus.chan_enable[c] && grant[i] && (win_rank[i] == chan_rank[c])) begin
          cdb_valid_d[c]   = 1'b1;
          cdb_source_d[c]  = SRC_W'(i);
          cdb_payload_d[c] = bus.req_payload[i];
        end
      end
    end

    if (n_win > 0) begin
      rr_ptr_d = (last_win == LAST_IDX) ? '0 : last_win + SRC_W'(1);
    end

    // A flushed cycle is invisible to fairness: counters freeze rather than clear or advance.
    if (!bus.flush) begin
      for (int i = 0; i < REQUESTERS; i++) begin
        if (!bus.req[i] || grant[i]) begin
          wait_cnt_d[i] = '0;
        end else if (wait_cnt_q[i] != CNT_MAX) begin
          wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q      <= '0;
      wait_cnt_q    <= '0;
      cdb_valid_q   <= '0;
      cdb_payload_q <= '0;
      cdb_source_q  <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      wait_cnt_q    <= wait_cnt_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_payload_q <= cdb_payload_d;
      cdb_source_q  <= cdb_source_d;
    end
  end

  assign bus.grant       = grant;
  assign bus.starved     = starved;
  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_payload = cdb_payload_q;
  assign bus.cdb_source  = cdb_source_q;

  a_grant_requested: assert property (@(posedge clock) disable iff (!reset)
    (grant & ~bus.req) == '0);
  a_grant_fits_channels: assert property (@(posedge clock) disable iff (!reset)
    $countones(grant) <= $countones(bus.chan_enable));
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomised checks of the CDB arbiter: ordering, masking, starvation, flush, reset, payload integrity.
module tb_cdb_arbiter;
  localparam int REQ = 5;
  localparam int CH  = 2;
  localparam int PW  = 72;
  localparam int MW  = 7;
  localparam int SW  = $clog2(REQ);

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  cdb_arbiter_if #(.REQUESTERS(REQ), .CHANNELS(CH), .PAYLOAD_W(PW)) bus ();

  cdb_arbiter #(
    .REQUESTERS(REQ), .CHANNELS(CH), .PAYLOAD_W(PW), .MAX_WAIT(MW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [4:0] rr_grant [4] = '{5'b00011, 5'b01100, 5'b10001, 5'b00110};
  int         rr_src0  [4] = '{0, 2, 4, 1};
  int         rr_src1  [4] = '{1, 3, 0, 2};

  logic [REQ-1:0] rq, last_g, g;
  logic [PW-1:0]  rp [REQ];
  logic [95:0]    tmp96;
  logic [CH-1:0]  en, exp_mask;
  logic           fl;
  int             n_exp, k, s;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [PW-1:0] mk_pay(input int i);
    return {64'hFACE_CAFE_0000_0000 + 64'(i), 8'(i)};
  endfunction

  initial begin
    reset           = 1'b0;
    bus.flush       = 1'b0;
    bus.chan_enable = 2'b11;
    bus.req         = 5'b11111;
    for (int i = 0; i < REQ; i++) bus.req_payload[i] = mk_pay(i);

    // Reset held with everyone requesting
    for (int t = 0; t < 3; t++) begin
      tick();
      check_eq("rst_grant", bus.grant, 0);
      check_eq("rst_valid", bus.cdb_valid, 0);
    end
    check_eq("rst_starved", bus.starved, 0);
    check_eq("rst_source", bus.cdb_source, 0);
    check_eq("rst_payload", bus.cdb_payload, 0);

    // Release and round robin over four cycles
    reset = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      check_eq("rr_grant", bus.grant, rr_grant[t]);
      tick();
      check_eq("rr_valid", bus.cdb_valid, 2'b11);
      check_eq("rr_src0", bus.cdb_source[0], rr_src0[t]);
      check_eq("rr_src1", bus.cdb_source[1], rr_src1[t]);
      check_eq("rr_pay0", bus.cdb_payload[0], mk_pay(rr_src0[t]));
    end

    // Channel mask: only channel 1, rr_ptr now 3 so unit 1 precedes unit 2
    bus.chan_enable = 2'b10;
    bus.req         = 5'b00110;
    #1;
    check_eq("mask_grant", bus.grant, 5'b00010);
    tick();
    bus.chan_enable = 2'b00;
    #1;
    check_eq("mask_valid_inflight", bus.cdb_valid, 2'b10);
    check_eq("mask_src1", bus.cdb_source[1], 1);
    check_eq("mask_pay1", bus.cdb_payload[1], mk_pay(1));
    check_eq("mask_src0_hold", bus.cdb_source[0], 1);

    // Starvation: unit 4 waits with no channel available
    bus.req = 5'b10000;
    #1;
    check_eq("nochan_grant", bus.grant, 0);
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 6) check_eq("starve_not_yet", bus.starved, 0);
      if (t == 7) check_eq("starve_set", bus.starved, 5'b10000);
    end
    bus.req         = 5'b11111;
    bus.chan_enable = 2'b01;
    #1;
    check_eq("starve_grant", bus.grant, 5'b10000);
    tick();
    check_eq("starve_valid", bus.cdb_valid, 2'b01);
    check_eq("starve_src", bus.cdb_source[0], 4);
    check_eq("starve_pay", bus.cdb_payload[0], mk_pay(4));
    check_eq("starve_clear", bus.starved, 0);
    #1;
    check_eq("post_starve_grant", bus.grant, 5'b00001);
    tick();
    check_eq("post_starve_src", bus.cdb_source[0], 0);

    // Flush: rr_ptr is 1 and must survive the flushed cycle
    bus.flush       = 1'b1;
    bus.req         = 5'b00011;
    bus.chan_enable = 2'b11;
    #1;
    check_eq("flush_grant", bus.grant, 0);
    tick();
    check_eq("flush_valid", bus.cdb_valid, 0);
    bus.flush = 1'b0;
    #1;
    check_eq("unflush_grant", bus.grant, 5'b00011);
    tick();
    check_eq("unflush_valid", bus.cdb_valid, 2'b11);
    check_eq("unflush_src0", bus.cdb_source[0], 1);
    check_eq("unflush_src1", bus.cdb_source[1], 0);

    // Asynchronous reset while a broadcast is on the bus
    reset = 1'b0;
    #1;
    check_eq("arst_valid", bus.cdb_valid, 0);
    check_eq("arst_grant", bus.grant, 0);
    tick();
    reset = 1'b1;
    #1;
    check_eq("arst_rel_grant", bus.grant, 5'b00011);
    tick();
    check_eq("arst_rel_src0", bus.cdb_source[0], 0);
    check_eq("arst_rel_src1", bus.cdb_source[1], 1);

    // Randomised traffic against a scoreboard of granted payloads
    rq     = '0;
    last_g = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rq = rq & ~last_g;
      for (int i = 0; i < REQ; i++) begin
        if (!rq[i] && ($urandom_range(0, 1) == 1)) begin
          tmp96 = {$urandom, $urandom, $urandom};
          rp[i] = tmp96[PW-1:0];
          rq[i] = 1'b1;
        end
      end
      en = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) en = 2'b11;
      fl = ($urandom_range(0, 15) == 0);
      bus.req         = rq;
      bus.chan_enable = en;
      bus.flush       = fl;
      for (int i = 0; i < REQ; i++) bus.req_payload[i] = rp[i];
      #1;
      g = bus.grant;
      n_exp = ($countones(rq) < $countones(en)) ? $countones(rq) : $countones(en);
      if (fl) n_exp = 0;
      check_eq("rnd_grant_subset", g & ~rq, 0);
      check_eq("rnd_grant_count", $countones(g), n_exp);
      exp_mask = '0;
      k = 0;
      for (int c = 0; c < CH; c++) begin
        if (en[c] && (k < n_exp)) begin
          exp_mask[c] = 1'b1;
          k++;
        end
      end
      last_g = g;
      tick();
      check_eq("rnd_valid_mask", bus.cdb_valid, exp_mask);
      for (int c = 0; c < CH; c++) begin
        if (bus.cdb_valid[c]) begin
          s = int'(bus.cdb_source[c]);
          check_eq("rnd_src_granted", g[s], 1'b1);
          check_eq("rnd_payload", bus.cdb_payload[c], rp[s]);
          for (int d = c + 1; d < CH; d++) begin
            if (bus.cdb_valid[d]) check_eq("rnd_src_distinct", bus.cdb_source[d] == bus.cdb_source[c], 1'b0);
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
